// File: rtl/tl_rx_pkg.sv
// Shared definitions for the TLP receive path: FSM encoding, beat geometry,
// payload-count limits and the last-DW index helper.
package tl_rx_pkg;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_PAYLOAD = 2'd1,
      ST_CHECK   = 2'd2
   } rx_state_e;

   localparam int TL_BEAT_DW = 8;
   localparam int CNT_W      = 11;
   // A Length field of zero encodes the maximum payload.
   localparam logic [CNT_W-1:0] MAX_PLD_DW = 11'd1024;

   function automatic logic [2:0] last_index(input logic [CNT_W-1:0] cnt,
                                             input logic [CNT_W-1:0] mask);
      if (cnt == 11'd0) begin
         return 3'd0;
      end else begin
         return 3'((cnt - 11'd1) & mask);
      end
   endfunction

endpackage

// File: rtl/tl_rx_dw_counter.sv
// Saturating payload DW accumulator; exposes the value it takes at the next edge
// so the tracker can register its outputs against the post-update count.
module tl_rx_dw_counter
   import tl_rx_pkg::*;
(
   input  logic             clk,
   input  logic             arst,
   input  logic             load,
   input  logic             add,
   input  logic [3:0]       inc,
   output logic [CNT_W-1:0] cnt_nxt
);

   logic [CNT_W-1:0] cnt_r;
   logic [CNT_W:0]   sum_s;

   // Next count: load on header beat, saturating add on payload beats.
   always_comb begin
      sum_s = {1'b0, cnt_r} + {8'd0, inc};
      if (load) begin
         cnt_nxt = {7'd0, inc};
      end else if (add) begin
         if (sum_s[CNT_W]) begin
            cnt_nxt = {CNT_W{1'b1}};
         end else begin
            cnt_nxt = sum_s[CNT_W-1:0];
         end
      end else begin
         cnt_nxt = cnt_r;
      end
   end

   // Count register.
   always_ff @(posedge clk or negedge arst) begin
      if (!arst) begin
         cnt_r <= 11'd0;
      end else begin
         cnt_r <= cnt_nxt;
      end
   end

endmodule

// File: rtl/tl_rx_payload_tracker.sv
// Tracks received payload DWs of a TLP against its header Length and produces
// the completion/overrun status plus a one-cycle strobe for the malformed check.
module tl_rx_payload_tracker
   import tl_rx_pkg::*;
#(
   parameter int LENGTH_WIDTH = 10,
   parameter int BEAT_DW      = TL_BEAT_DW
)
(
   input  logic                    clk,
   input  logic                    arst,
   input  logic                    i_sop,
   input  logic                    i_valid,
   input  logic                    i_hdr_has_data,
   input  logic [LENGTH_WIDTH-1:0] i_length,
   input  logic [3:0]              i_pld_dw,
   input  logic                    i_eop,
   output logic                    o_rcv_done,
   output logic [2:0]              o_last_dw,
   output logic [2:0]              o_last_rcv_data,
   output logic                    o_eop_q,
   output logic                    o_malformed_en,
   output logic                    o_overrun
);

   localparam logic [CNT_W-1:0] DW_MASK = CNT_W'(BEAT_DW - 1);

   rx_state_e        state_r;
   rx_state_e        state_nxt_s;
   logic [CNT_W-1:0] exp_cnt_r;
   logic [CNT_W-1:0] exp_nxt_s;
   logic [CNT_W-1:0] rcv_nxt_s;
   logic             sop_beat_s;
   logic             pld_beat_s;
   logic             eop_beat_s;
   logic             stray_sop_s;
   logic             rcv_done_nxt_s;
   logic             overrun_nxt_s;
   logic [2:0]       last_dw_nxt_s;
   logic [2:0]       last_rcv_nxt_s;
   logic             malformed_nxt_s;

   // Beat qualification; a sop seen mid-payload is kept as data but flagged.
   always_comb begin
      sop_beat_s  = i_valid && i_sop && (state_r == ST_IDLE);
      pld_beat_s  = i_valid && (state_r == ST_PAYLOAD);
      eop_beat_s  = (sop_beat_s || pld_beat_s) && i_eop;
      stray_sop_s = pld_beat_s && i_sop;
   end

   // Expected payload count latched from the header.
   always_comb begin
      if (!sop_beat_s) begin
         exp_nxt_s = exp_cnt_r;
      end else if (!i_hdr_has_data) begin
         exp_nxt_s = 11'd0;
      end else if (i_length == {LENGTH_WIDTH{1'b0}}) begin
         exp_nxt_s = MAX_PLD_DW;
      end else begin
         exp_nxt_s = CNT_W'(i_length);
      end
   end

   tl_rx_dw_counter u_rcv_cnt (
      .clk     (clk),
      .arst    (arst),
      .load    (sop_beat_s),
      .add     (pld_beat_s),
      .inc     (i_pld_dw),
      .cnt_nxt (rcv_nxt_s)
   );

   // State register.
   always_ff @(posedge clk or negedge arst) begin
      if (!arst) begin
         state_r <= ST_IDLE;
      end else begin
         state_r <= state_nxt_s;
      end
   end

   // Next-state logic.
   always_comb begin
      state_nxt_s = state_r;
      case (state_r)
         ST_IDLE: begin
            if (i_valid && i_sop) begin
               state_nxt_s = i_eop ? ST_CHECK : ST_PAYLOAD;
            end else begin
               state_nxt_s = ST_IDLE;
            end
         end
         ST_PAYLOAD: begin
            if (i_valid && i_eop) begin
               state_nxt_s = ST_CHECK;
            end else begin
               state_nxt_s = ST_PAYLOAD;
            end
         end
         ST_CHECK: state_nxt_s = ST_IDLE;
         default:  state_nxt_s = ST_IDLE;
      endcase
   end

   // Output next values; overrun is sticky until the FSM returns to idle.
   always_comb begin
      malformed_nxt_s = (state_nxt_s == ST_CHECK);
      rcv_done_nxt_s  = (state_nxt_s != ST_IDLE) && (rcv_nxt_s == exp_nxt_s);
      if (state_nxt_s == ST_IDLE) begin
         overrun_nxt_s = 1'b0;
      end else begin
         overrun_nxt_s = o_overrun || (rcv_nxt_s > exp_nxt_s) || stray_sop_s;
      end
      last_dw_nxt_s = last_index(exp_nxt_s, DW_MASK);
      if (eop_beat_s) begin
         last_rcv_nxt_s = last_index(CNT_W'(i_pld_dw), DW_MASK);
      end else begin
         last_rcv_nxt_s = o_last_rcv_data;
      end
   end

   // Expected-count and output registers.
   always_ff @(posedge clk or negedge arst) begin
      if (!arst) begin
         exp_cnt_r       <= 11'd0;
         o_rcv_done      <= 1'b0;
         o_last_dw       <= 3'd0;
         o_last_rcv_data <= 3'd0;
         o_eop_q         <= 1'b0;
         o_malformed_en  <= 1'b0;
         o_overrun       <= 1'b0;
      end else begin
         exp_cnt_r       <= exp_nxt_s;
         o_rcv_done      <= rcv_done_nxt_s;
         o_last_dw       <= last_dw_nxt_s;
         o_last_rcv_data <= last_rcv_nxt_s;
         o_eop_q         <= eop_beat_s;
         o_malformed_en  <= malformed_nxt_s;
         o_overrun       <= overrun_nxt_s;
      end
   end

endmodule

// File: tb/tb_tl_rx_payload_tracker.sv
// Scoreboard bench: each TLP pushes its expected check-cycle status; a monitor
// pops and compares on every o_malformed_en strobe.
module tb_tl_rx_payload_tracker;

   logic       clk = 1'b0;
   logic       arst = 1'b0;
   logic       i_sop = 1'b0;
   logic       i_valid = 1'b0;
   logic       i_hdr_has_data = 1'b0;
   logic [9:0] i_length = 10'd0;
   logic [3:0] i_pld_dw = 4'd0;
   logic       i_eop = 1'b0;
   logic       o_rcv_done;
   logic [2:0] o_last_dw;
   logic [2:0] o_last_rcv_data;
   logic       o_eop_q;
   logic       o_malformed_en;
   logic       o_overrun;

   typedef struct packed {
      logic       done;
      logic [2:0] ld;
      logic [2:0] lr;
      logic       eq;
      logic       ov;
   } exp_t;

   exp_t sb_q[$];
   int   checks  = 0;
   int   errors  = 0;
   int   pushes  = 0;
   int   strobes = 0;

   tl_rx_payload_tracker #(.LENGTH_WIDTH(10), .BEAT_DW(8)) dut (
      .clk             (clk),
      .arst            (arst),
      .i_sop           (i_sop),
      .i_valid         (i_valid),
      .i_hdr_has_data  (i_hdr_has_data),
      .i_length        (i_length),
      .i_pld_dw        (i_pld_dw),
      .i_eop           (i_eop),
      .o_rcv_done      (o_rcv_done),
      .o_last_dw       (o_last_dw),
      .o_last_rcv_data (o_last_rcv_data),
      .o_eop_q         (o_eop_q),
      .o_malformed_en  (o_malformed_en),
      .o_overrun       (o_overrun)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic push(input logic done, input logic [2:0] ld, input logic [2:0] lr,
                       input logic eq, input logic ov);
      exp_t e;
      e.done = done; e.ld = ld; e.lr = lr; e.eq = eq; e.ov = ov;
      sb_q.push_back(e);
      pushes++;
   endtask

   task automatic beat(input logic sop, input logic hdr, input logic [9:0] len,
                       input logic [3:0] pld, input logic eop);
      @(negedge clk);
      i_valid = 1'b1; i_sop = sop; i_hdr_has_data = hdr;
      i_length = len; i_pld_dw = pld; i_eop = eop;
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(negedge clk);
         i_valid = 1'b0; i_sop = 1'b0; i_eop = 1'b0; i_pld_dw = 4'd0;
      end
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_rcv_done"},  o_rcv_done,      0);
      check({tag, "_last_dw"},   o_last_dw,       0);
      check({tag, "_last_rcv"},  o_last_rcv_data, 0);
      check({tag, "_eop_q"},     o_eop_q,         0);
      check({tag, "_strobe"},    o_malformed_en,  0);
      check({tag, "_overrun"},   o_overrun,       0);
   endtask

   // Monitor: every strobe must match the oldest outstanding expectation.
   always @(negedge clk) begin
      if (arst && o_malformed_en) begin
         strobes++;
         if (sb_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_strobe: got strobe expected none");
         end else begin : pop_cmp
            exp_t e;
            e = sb_q.pop_front();
            check("rcv_done", o_rcv_done,      e.done);
            check("last_dw",  o_last_dw,       e.ld);
            check("last_rcv", o_last_rcv_data, e.lr);
            check("eop_q",    o_eop_q,         e.eq);
            check("overrun",  o_overrun,       e.ov);
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      #3;
      check_all_zero("reset");
      @(negedge clk);
      arst = 1'b1;
      idle(2);

      // Length 5 in one beat; a second beat landing in CHECK must be ignored.
      push(1'b1, 3'd4, 3'd4, 1'b1, 1'b0);
      beat(1'b1, 1'b1, 10'd5, 4'd5, 1'b1);
      beat(1'b1, 1'b1, 10'd3, 4'd3, 1'b1);
      idle(3);

      // Length 0 = 1024 DW over 128 full beats.
      push(1'b1, 3'd7, 3'd7, 1'b1, 1'b0);
      beat(1'b1, 1'b1, 10'd0, 4'd8, 1'b0);
      for (int i = 2; i <= 127; i++) beat(1'b0, 1'b1, 10'd0, 4'd8, 1'b0);
      idle(1);
      check("done_before_last_beat", o_rcv_done, 0);
      check("overrun_before_last_beat", o_overrun, 0);
      check("last_dw_mid_payload", o_last_dw, 7);
      beat(1'b0, 1'b1, 10'd0, 4'd8, 1'b1);
      idle(3);

      // Length 10 receiving 12 DW.
      push(1'b0, 3'd1, 3'd3, 1'b1, 1'b1);
      beat(1'b1, 1'b1, 10'd10, 4'd8, 1'b0);
      beat(1'b0, 1'b1, 10'd10, 4'd4, 1'b1);
      idle(3);

      // Header without payload.
      push(1'b1, 3'd0, 3'd0, 1'b1, 1'b0);
      beat(1'b1, 1'b0, 10'd7, 4'd0, 1'b1);
      idle(3);

      // Reset during the second beat of a 3-beat TLP; the orphan eop is ignored.
      beat(1'b1, 1'b1, 10'd24, 4'd8, 1'b0);
      beat(1'b0, 1'b1, 10'd24, 4'd8, 1'b0);
      #2 arst = 1'b0;
      #1 check_all_zero("midreset");
      @(negedge clk);
      arst = 1'b1;
      i_valid = 1'b0;
      beat(1'b0, 1'b1, 10'd24, 4'd8, 1'b1);
      idle(5);
      check_all_zero("post_release");

      // 20 DW with valid gaps between beats.
      push(1'b1, 3'd3, 3'd3, 1'b1, 1'b0);
      beat(1'b1, 1'b1, 10'd20, 4'd8, 1'b0);
      idle(2);
      beat(1'b0, 1'b1, 10'd20, 4'd8, 1'b0);
      idle(3);
      beat(1'b0, 1'b1, 10'd20, 4'd4, 1'b1);
      idle(3);

      // Stray sop inside the payload: no restart, overrun forced.
      push(1'b1, 3'd7, 3'd7, 1'b1, 1'b1);
      beat(1'b1, 1'b1, 10'd16, 4'd8, 1'b0);
      beat(1'b1, 1'b1, 10'd3, 4'd8, 1'b1);
      idle(3);

      for (int i = 0; i < 20 && sb_q.size() > 0; i++) @(negedge clk);
      check("queue_drained", sb_q.size(), 0);
      check("strobe_count", strobes, pushes);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
